control_sequencer: RTL and testbench

Parametrised microcoded control sequencer for the EDiC CPU. Holds the instruction register and step counter. Forms the control-store address from the ALU flags, the instruction and the step, and gates the returned control word onto the datapath. On top of a fixed-length sequencer it adds variable-length instructions (microcode end bit), halt/resume, single-step, wait-state stall and step-overrun detection. The control store is external combinational memory.

---
 rtl/control_sequencer_if.sv | 34 +++
 rtl/control_sequencer.sv | 94 +++++++++
 tb/tb_control_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Bus between the EDiC control sequencer and its datapath / control store.
// The sequencer itself connects through the slave modport.
interface control_sequencer_if #(
  parameter int INSTR_WIDTH = 8,
  parameter int STEP_WIDTH  = 3,
  parameter int FLAG_WIDTH  = 2,
  parameter int CTRL_WIDTH  = 16,
  parameter int IMM_WIDTH   = 3
);
  logic [FLAG_WIDTH-1:0]                        i_flags;
  logic [INSTR_WIDTH-1:0]                       i_instruction;
  logic [CTRL_WIDTH-1:0]                        i_ucodeData;
  logic                                         i_stall;
  logic                                         i_resume;
  logic                                         i_singleStep;
  logic [FLAG_WIDTH+INSTR_WIDTH+STEP_WIDTH-1:0] o_ucodeAddr;
  logic [CTRL_WIDTH-2:0]                        o_ctrl;
  logic                                         o_fetch;
  logic [IMM_WIDTH-1:0]                         o_immediate;
  logic [INSTR_WIDTH-1:0]                       o_instr;
  logic [STEP_WIDTH-1:0]                        o_step;
  logic                                         o_halted;
  logic                                         o_overrun;

  modport slave (
    input  i_flags, i_instruction, i_ucodeData, i_stall, i_resume, i_singleStep,
    output o_ucodeAddr, o_ctrl, o_fetch, o_immediate, o_instr, o_step, o_halted, o_overrun
  );

  modport master (
    output i_flags, i_instruction, i_ucodeData, i_stall, i_resume, i_singleStep,
    input  o_ucodeAddr, o_ctrl, o_fetch, o_immediate, o_instr, o_step, o_halted, o_overrun
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: instruction register, step counter, halt/resume,
// single-step, wait-state stall and step-overrun detection. Control store is external.
module control_sequencer #(
  parameter int                     INSTR_WIDTH  = 8,
  parameter int                     STEP_WIDTH   = 3,
  parameter int                     FLAG_WIDTH   = 2,
  parameter int                     CTRL_WIDTH   = 16,
  parameter int                     IMM_LSB      = 3,
  parameter int                     IMM_WIDTH    = 3,
  parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE  = '1,
  parameter int                     START_HALTED = 0
) (
  input logic                 i_clk,
  input logic                 i_reset,
  control_sequencer_if.slave  bus
);
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  localparam logic [STEP_WIDTH-1:0] MAX_STEP  = '1;
  localparam state_e                RST_STATE = (START_HALTED != 0) ? HALT : RUN;

  state_e                 state_q, state_d;
  logic [STEP_WIDTH-1:0]  step_q, step_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   overrun_q, overrun_d;

  logic running, halt_det, u_end, exec_step;

  assign running   = (state_q == RUN);
  assign u_end     = bus.i_ucodeData[0];
  assign exec_step = (step_q > STEP_WIDTH'(1));
  // Halt opcode is caught at its first execute step, before any of its microcode acts.
  assign halt_det  = running && (step_q == STEP_WIDTH'(2)) && (instr_q == HALT_OPCODE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= RST_STATE;
      step_q    <= '0;
      instr_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      instr_q   <= instr_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    instr_d   = instr_q;
    overrun_d = overrun_q;
    if (!bus.i_stall) begin
      case (state_q)
        RUN: begin
          if (step_q == STEP_WIDTH'(1)) instr_d = bus.i_instruction;
          if (halt_det) begin
            state_d = HALT;
            step_d  = '0;
          end else if (exec_step && u_end) begin
            step_d = '0;
            if (bus.i_singleStep) state_d = HALT;
          end else if (step_q == MAX_STEP) begin
            step_d    = '0;
            overrun_d = 1'b1;
            if (bus.i_singleStep) state_d = HALT;
          end else begin
            step_d = step_q + STEP_WIDTH'(1);
          end
        end
        HALT: begin
          step_d = '0;
          if (bus.i_resume) state_d = RUN;
        end
        default: begin
          state_d = RST_STATE;
          step_d  = '0;
        end
      endcase
    end
  end

  assign bus.o_ucodeAddr = {bus.i_flags, instr_q, step_q};
  // Reset term keeps the datapath quiet while reset is held even though RUN is the reset state.
  assign bus.o_ctrl      = (running && !halt_det && !i_reset) ?
                           bus.i_ucodeData[CTRL_WIDTH-1:1] : '0;
  assign bus.o_fetch     = running && (step_q == STEP_WIDTH'(1));
  assign bus.o_immediate = instr_q[IMM_LSB +: IMM_WIDTH];
  assign bus.o_instr     = instr_q;
  assign bus.o_step      = step_q;
  assign bus.o_halted    = (state_q == HALT);
  assign bus.o_overrun   = overrun_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a tiny combinational control-store model:
// every word carries rom_ctrl on the control lines and uEnd at step end_step (0 = never).
module tb_control_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [14:0] rom_ctrl = 15'h0001;
  logic [2:0]  end_step = 3'd2;

  control_sequencer_if #(.INSTR_WIDTH(8), .STEP_WIDTH(3), .FLAG_WIDTH(2),
                         .CTRL_WIDTH(16), .IMM_WIDTH(3)) bus ();

  control_sequencer #(.INSTR_WIDTH(8), .STEP_WIDTH(3), .FLAG_WIDTH(2), .CTRL_WIDTH(16),
                      .IMM_LSB(3), .IMM_WIDTH(3), .HALT_OPCODE(8'hFF), .START_HALTED(0))
    dut (.i_clk(clk), .i_reset(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  assign bus.i_ucodeData = {rom_ctrl, (end_step != 3'd0) && (bus.o_ucodeAddr[2:0] == end_step)};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.i_flags       = 2'b00;
    bus.i_instruction = 8'h05;
    bus.i_stall       = 1'b0;
    bus.i_resume      = 1'b0;
    bus.i_singleStep  = 1'b0;

    // Reset state
    #3;
    check("rst_step", 32'(bus.o_step), 0);
    check("rst_instr", 32'(bus.o_instr), 0);
    check("rst_ctrl", 32'(bus.o_ctrl), 0);
    check("rst_halted", 32'(bus.o_halted), 0);
    check("rst_overrun", 32'(bus.o_overrun), 0);
    check("rst_fetch", 32'(bus.o_fetch), 0);
    #9 rst = 1'b0;
    #1;

    // Opcode 0x05, uEnd at step 2
    check("t1_s0_ctrl", 32'(bus.o_ctrl), 32'h1);
    check("t1_s0_fetch", 32'(bus.o_fetch), 0);
    tick();
    check("t1_s1_step", 32'(bus.o_step), 1);
    check("t1_s1_fetch", 32'(bus.o_fetch), 1);
    check("t1_s1_ctrl", 32'(bus.o_ctrl), 32'h1);
    tick();
    check("t1_s2_step", 32'(bus.o_step), 2);
    check("t1_s2_instr", 32'(bus.o_instr), 32'h05);
    check("t1_s2_fetch", 32'(bus.o_fetch), 0);
    check("t1_s2_ctrl", 32'(bus.o_ctrl), 32'h1);
    check("t1_s2_addr", 32'(bus.o_ucodeAddr), 32'h02A);
    check("t1_s2_imm", 32'(bus.o_immediate), 0);
    tick();
    check("t1_end_step", 32'(bus.o_step), 0);

    // Opcode 0x10, no uEnd: overrun
    end_step = 3'd0;
    bus.i_instruction = 8'h10;
    tick(); tick();
    check("t2_instr", 32'(bus.o_instr), 32'h10);
    check("t2_imm", 32'(bus.o_immediate), 2);
    repeat (5) tick();
    check("t2_s7_step", 32'(bus.o_step), 7);
    check("t2_s7_ovr", 32'(bus.o_overrun), 0);
    tick();
    check("t2_wrap_step", 32'(bus.o_step), 0);
    check("t2_wrap_ovr", 32'(bus.o_overrun), 1);
    end_step = 3'd2;
    bus.i_instruction = 8'h05;
    repeat (3) tick();
    check("t2_sticky_ovr", 32'(bus.o_overrun), 1);
    check("t2_next_step", 32'(bus.o_step), 0);

    // Halt opcode, then resume
    bus.i_instruction = 8'hFF;
    tick(); tick();
    check("t3_s2_instr", 32'(bus.o_instr), 32'hFF);
    check("t3_s2_ctrl", 32'(bus.o_ctrl), 0);
    check("t3_s2_halted", 32'(bus.o_halted), 0);
    tick();
    check("t3_halted", 32'(bus.o_halted), 1);
    check("t3_h_step", 32'(bus.o_step), 0);
    check("t3_h_ctrl", 32'(bus.o_ctrl), 0);
    tick();
    check("t3_hold", 32'(bus.o_halted), 1);
    check("t3_h_fetch", 32'(bus.o_fetch), 0);
    bus.i_resume = 1'b1;
    bus.i_instruction = 8'h06;
    tick();
    bus.i_resume = 1'b0;
    check("t3_resumed", 32'(bus.o_halted), 0);
    check("t3_r_step", 32'(bus.o_step), 0);
    tick();
    check("t3_r_fetch", 32'(bus.o_fetch), 1);
    tick();
    check("t3_r_instr", 32'(bus.o_instr), 32'h06);
    tick();

    // Stall at step 3, then stall at step 1
    end_step = 3'd5;
    bus.i_flags = 2'b01;
    bus.i_instruction = 8'h0D;
    repeat (3) tick();
    check("t4_s3", 32'(bus.o_step), 3);
    bus.i_stall = 1'b1;
    repeat (3) begin
      tick();
      check("t4_stall_step", 32'(bus.o_step), 3);
      check("t4_stall_addr", 32'(bus.o_ucodeAddr), 32'h86B);
      check("t4_stall_ctrl", 32'(bus.o_ctrl), 32'h1);
    end
    bus.i_stall = 1'b0;
    tick();
    check("t4_release", 32'(bus.o_step), 4);
    tick(); tick();
    check("t4_done", 32'(bus.o_step), 0);
    end_step = 3'd2;
    tick();
    bus.i_instruction = 8'h21;
    bus.i_stall = 1'b1;
    tick();
    check("t4_s1_hold_step", 32'(bus.o_step), 1);
    check("t4_s1_hold_instr", 32'(bus.o_instr), 32'h0D);
    bus.i_stall = 1'b0;
    tick();
    check("t4_s1_load", 32'(bus.o_instr), 32'h21);
    tick();

    // Single-step with a 4-step instruction
    end_step = 3'd3;
    bus.i_singleStep = 1'b1;
    bus.i_instruction = 8'h07;
    repeat (3) tick();
    check("t5_s3", 32'(bus.o_step), 3);
    check("t5_s3_run", 32'(bus.o_halted), 0);
    tick();
    check("t5_halt1", 32'(bus.o_halted), 1);
    bus.i_resume = 1'b1;
    bus.i_instruction = 8'h08;
    tick();
    bus.i_resume = 1'b0;
    check("t5_res1", 32'(bus.o_halted), 0);
    tick(); tick();
    check("t5_instr2", 32'(bus.o_instr), 32'h08);
    tick(); tick();
    check("t5_halt2", 32'(bus.o_halted), 1);
    bus.i_singleStep = 1'b0;
    bus.i_resume = 1'b1;
    tick();
    bus.i_resume = 1'b0;
    check("t5_res2", 32'(bus.o_halted), 0);

    // Async reset mid-instruction
    end_step = 3'd7;
    bus.i_flags = 2'b11;
    bus.i_instruction = 8'h33;
    repeat (5) tick();
    check("t6_s5", 32'(bus.o_step), 5);
    check("t6_instr", 32'(bus.o_instr), 32'h33);
    check("t6_ovr_pre", 32'(bus.o_overrun), 1);
    rst = 1'b1;
    #1;
    check("t6_step", 32'(bus.o_step), 0);
    check("t6_instr0", 32'(bus.o_instr), 0);
    check("t6_ctrl", 32'(bus.o_ctrl), 0);
    check("t6_ovr", 32'(bus.o_overrun), 0);
    check("t6_addr", 32'(bus.o_ucodeAddr), 32'h1800);
    #10 rst = 1'b0;
    tick();
    check("t6_after", 32'(bus.o_step), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
